// File: rtl/gf32_serial_mult.sv
// Bit-serial GF(2^32) multiplier: MSB-first Horner iteration, one product per 32 BUSY cycles,
// with optional chaining of the previous product into the next multiplicand.
`timescale 1ns/1ps
module gf32_serial_mult #(
    parameter logic [31:0] POLY = 32'h00400007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_chain,
    input  logic        in_clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] prod_q, prod_d;
    logic [31:0] last_q, last_d;
    logic [31:0] step;

    function automatic logic [31:0] mul_alpha(input logic [31:0] x);
        return x[31] ? ({x[30:0], 1'b0} ^ POLY) : {x[30:0], 1'b0};
    endfunction

    // in_ready is held low while rst is asserted, even though state already reads IDLE.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign out_prod  = prod_q;

    assign step = mul_alpha(acc_q) ^ (b_q[cnt_q] ? a_q : 32'h0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a ^ ((in_chain && !in_clear) ? last_q : 32'h0);
                    b_d     = in_b;
                    acc_d   = 32'h0;
                    cnt_d   = 5'd31;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d = step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    prod_d  = step;
                    last_d  = step;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            acc_q   <= 32'h0;
            cnt_q   <= 5'd0;
            prod_q  <= 32'h0;
            last_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_gf32_serial_mult.sv
// Directed and randomised checks of gf32_serial_mult against hand values and a GF(2^32) model.
`timescale 1ns/1ps
module tb_gf32_serial_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        in_chain = 1'b0;
    logic        in_clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_prod;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_last = 32'h0;

    gf32_serial_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_chain  (in_chain),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    always #5 clk = ~clk;

    // Full carry-less product followed by top-down reduction.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = 64'h0;
        logic [63:0] f = 64'h1_0040_0007;
        for (int i = 0; i < 32; i++)
            if (b[i]) p = p ^ ({32'h0, a} << i);
        for (int i = 63; i >= 32; i--)
            if (p[i]) p = p ^ (f << (i - 32));
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, wait for out_valid, stall, then handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ch,
                          input logic cl, input int stall, output logic [31:0] prod,
                          output int lat);
        int guard = 0;
        in_a = a; in_b = b; in_chain = ch; in_clear = cl; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        repeat (stall) tick();
        prod = out_prod;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_prod !== 32'h0) begin
            n_fail++; $display("FAIL reset_out got v=%b p=%h exp v=0 p=0", out_valid, out_prod);
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_identity();
        logic [31:0] p;
        int lat;
        run_op(32'h00000001, 32'h12345678, 1'b0, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'h12345678) begin
            n_fail++; $display("FAIL identity_a1 got=%h exp=12345678", p);
        end
        n_tests++;
        if (lat !== 32) begin
            n_fail++; $display("FAIL latency got=%0d exp=32", lat);
        end
        run_op(32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL identity_b1 got=%h exp=deadbeef", p);
        end
    endtask

    task automatic test_reduction();
        logic [31:0] p;
        int lat;
        run_op(32'h80000000, 32'h00000002, 1'b0, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'h00400007) begin
            n_fail++; $display("FAIL reduce_x32 got=%h exp=00400007", p);
        end
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'hC0701C00) begin
            n_fail++; $display("FAIL reduce_x62 got=%h exp=c0701c00", p);
        end
    endtask

    task automatic test_chain();
        logic [31:0] p;
        int lat;
        run_op(32'h00000003, 32'h00000005, 1'b0, 1'b1, 0, p, lat);
        n_tests++;
        if (p !== 32'h0000000F) begin
            n_fail++; $display("FAIL chain_op1 got=%h exp=0000000f", p);
        end
        run_op(32'h00000001, 32'h00000002, 1'b1, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'h0000001C) begin
            n_fail++; $display("FAIL chain_op2 got=%h exp=0000001c", p);
        end
        run_op(32'h00000001, 32'h00000001, 1'b1, 1'b1, 0, p, lat);
        n_tests++;
        if (p !== 32'h00000001) begin
            n_fail++; $display("FAIL chain_op3 got=%h exp=00000001", p);
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        int bad = 0;
        in_a = 32'h00000007; in_b = 32'h00000003; in_chain = 1'b0; in_clear = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        // in_valid stays high with different operands throughout the stall.
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_prod !== 32'h00000009) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0 prod=%h", bad, out_prod);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_release got v=%b r=%b exp v=0 r=1",
                               out_valid, in_ready);
        end
        n_tests++;
        if (out_prod !== 32'h00000009) begin
            n_fail++; $display("FAIL prod_after_handshake got=%h exp=00000009", out_prod);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_spurious_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] p;
        int lat;
        run_op(32'h12345678, 32'h00000001, 1'b0, 1'b0, 0, p, lat);
        in_a = 32'h0000FFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_prod !== 32'h0) begin
            n_fail++; $display("FAIL rst_busy got v=%b p=%h exp v=0 p=0", out_valid, out_prod);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_busy_in_ready got=%b exp=1", in_ready);
        end
        run_op(32'h00000001, 32'h00000001, 1'b1, 1'b0, 0, p, lat);
        n_tests++;
        if (p !== 32'h00000001) begin
            n_fail++; $display("FAIL rst_clears_last got=%h exp=00000001", p);
        end
        model_last = 32'h00000001;
    endtask

    task automatic test_random();
        logic [31:0] a, b, p, eff, exp_p;
        logic ch, cl;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = $urandom;
            ch = 1'($urandom_range(0, 1));
            cl = 1'($urandom_range(0, 3) == 0);
            eff = a ^ ((ch && !cl) ? model_last : 32'h0);
            exp_p = gf_mul(eff, b);
            model_last = exp_p;
            run_op(a, b, ch, cl, $urandom_range(0, 3), p, lat);
            n_tests++;
            if (p !== exp_p || lat !== 32) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h ch=%b cl=%b got=%h lat=%0d exp=%h lat=32",
                         i, a, b, ch, cl, p, lat, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_reduction();
        test_chain();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
